psum_accumulator: RTL



---
 rtl/psum_acc_pkg.sv | 26 ++
 rtl/sat_adder.sv | 41 ++++
 rtl/psum_accumulator.sv | 122 ++++++++++++
 3 files changed

// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
// Saturation is compiled in with PSUM_ACC_SAT_EN (see sat_adder).
package psum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  localparam int PSUM_W_DEF = 16;
  localparam int ACC_W_DEF  = 32;
  localparam int CNT_W_DEF  = 12;

  // Extends the low w bits of v to 64 bits; callers truncate to their width.
  function automatic logic [63:0] ext_psum(input logic [63:0] v,
                                           input int unsigned w,
                                           input logic sgn);
    logic [63:0] mask;
    logic        msb;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    msb  = |(v & (64'd1 << (w - 1)));
    return (sgn && msb) ? (v | ~mask) : (v & mask);
  endfunction

endpackage

// File: rtl/sat_adder.sv
// W-bit adder with optional clamp; PSUM_ACC_SAT_EN enables saturation and
// overflow reporting, otherwise it wraps with ovf held low.
module sat_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         signed_mode,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] raw;
  assign raw = {1'b0, a} + {1'b0, b};

`ifdef PSUM_ACC_SAT_EN
  logic s_ovf;
  logic u_ovf;

  always_comb begin
    s_ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    u_ovf = raw[W];
    sum   = raw[W-1:0];
    ovf   = 1'b0;
    if (signed_mode) begin
      ovf = s_ovf;
      // Operands share a sign on overflow; clamp toward that sign.
      if (s_ovf) sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      ovf = u_ovf;
      if (u_ovf) sum = '1;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{raw[W], signed_mode};
  assign sum = raw[W-1:0];
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Temporal accumulator: sums acc_len beats of psum_in and holds the result
// on a valid/ready port. PSUM_ACC_SAT_EN selects saturating adds.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_signed,
  input  logic [CNT_W-1:0]  acc_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              busy
);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             sgn_q, sgn_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, out_valid_q, busy_q;

  logic             first;
  logic             beat;
  logic             sgn_eff;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W-1:0] beat_ext;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  // Mode and length come straight from the ports on a group's first beat.
  assign first    = (state_q == IDLE);
  assign beat     = in_valid & in_ready_q;
  assign sgn_eff  = first ? psum_signed : sgn_q;
  assign len_eff  = (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign beat_ext = ACC_W'(ext_psum(64'(psum_in), PSUM_W, sgn_eff));
  assign add_a    = first ? '0 : acc_q;

  sat_adder #(.W(ACC_W)) u_sat_adder (
    .a           (add_a),
    .b           (beat_ext),
    .signed_mode (sgn_eff),
    .sum         (add_sum),
    .ovf         (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sgn_d   = sgn_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          len_d   = len_eff;
          sgn_d   = psum_signed;
          acc_d   = add_sum;
          cnt_d   = CNT_W'(1);
          ovf_d   = add_ovf;
          state_d = (len_eff == CNT_W'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (cnt_inc == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      sgn_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sgn_q       <= sgn_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d != HOLD);
      out_valid_q <= (state_d == HOLD);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule
